des_dec_key_sched: RTL and testbench
====================================

Name: des_dec_key_sched

Overview:
Iterative DES subkey generator for the decryption direction. It delivers the 16 round subkeys in reverse order, K16 down to K1, one per handshake. It feeds the round datapath and its L/R round registers when that datapath runs in decrypt mode. Subkeys are produced on the fly by right-rotating the C/D halves, so no 16-entry key RAM is needed.

Parameters:
None. DES widths are fixed: KEY 64, C/D 28+28, SUBKEY 48.

Ports:
CLK       input   1      rising-edge clock
RST       input   1      synchronous, active-high reset
START     input   1      pulse; begin a new schedule from KEY (sampled in IDLE only)
KEY       input   [64:1] 64-bit DES key; bit 1 = MSB; parity bits 8,16,...,64 ignored
ADV       input   1      consumer has used current SUBKEY; advance to next
SUBKEY    output  [48:1] current subkey = PC-2(C,D); bit 1 = MSB
KIDX      output  [4:0]  index of subkey on SUBKEY (16..1); 0 when not valid
KEY_VALID output  1      SUBKEY/KIDX valid
BUSY      output  1      schedule in progress (KEY_VALID or loading)
DONE      output  1      one-cycle pulse after K1 is consumed

Behaviour:
- Reset: if RST is high at a clock edge, all of the following clear:
  - C, D, KIDX = 0; KEY_VALID, BUSY, DONE = 0; state = IDLE.
  - SUBKEY = PC-2(0,0) = 48'h0.
  - RST overrides START and ADV in the same cycle.
  - RST mid-schedule aborts immediately; no DONE is pulsed.
- States: IDLE, ISSUE, FIN.
- IDLE:
  - START=1 at edge t: {C,D} <= PC-1(KEY), KIDX <= 16, KEY_VALID <= 1, BUSY <= 1, state <= ISSUE.
  - K16 is visible after edge t. Latency START -> first subkey = 1 cycle.
  - Rationale: 28 total left shifts return C16/D16 to C0/D0, so K16 = PC-2(PC-1(KEY)) with no rotation.
- ISSUE:
  - SUBKEY is combinational PC-2 of the registered C/D, stable while ADV=0 (holds indefinitely).
  - ADV=1 with KIDX=i>1: C and D each rotate right by s(i), and KIDX <= i-1.
  - Shift table s(i) = left-shift count of encrypt round i: s(1,2,9,16)=1, all other rounds = 2.
  - Resulting rotate sequence after K16,K15,...,K2: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - ADV=1 with KIDX=1: KEY_VALID <= 0, KIDX <= 0, DONE <= 1, state <= FIN. C/D are not rotated.
  - START in ISSUE is ignored; no restart.
- FIN:
  - One cycle: DONE=1, BUSY=0, then state <= IDLE and DONE <= 0.
  - START in FIN is ignored. Earliest restart is the IDLE cycle after FIN.
- ADV while KEY_VALID=0 has no effect.
- Throughput: with ADV held high, 16 subkeys appear in 16 consecutive cycles, then the DONE cycle.
- KEY is sampled only on the START edge. Later KEY changes do not affect the schedule in progress.
- Permutations: PC-1 and PC-2 use FIPS 46-3 tables with 1-based MSB-first numbering, matching the datapath's [n:1] bus convention.

Test Plan:
1. Key 64'h133457799BBCDFF1, START pulse, ADV tied 1:
   - cycle+1: KIDX=16, SUBKEY=48'hCB3D8B0E17F5.
   - cycle+2: KIDX=15, SUBKEY=48'hBF918D3D3F0A.
   - cycle+16: KIDX=1, SUBKEY=48'h1B02EFFC7072.
   - cycle+17: DONE=1, KEY_VALID=0.
2. Same key, ADV toggled randomly (stalls of 0–5 cycles):
   - All 16 subkeys match test 1's sequence.
   - SUBKEY/KIDX stable during every stall.
   - Exactly one DONE pulse.
3. START re-asserted during ISSUE (at KIDX=9) with a different KEY:
   - Ignored; original sequence completes unchanged.
4. RST asserted at KIDX=7 with ADV=1:
   - Next cycle all outputs are at reset values and there is no DONE.
   - A following START with key 64'h0 gives SUBKEY=48'h0 for all 16 indices.
5. Parity independence: key 64'h133457799BBCDFF1 vs. the same key with all parity bits (8,16,...,64) flipped:
   - Identical 16-subkey sequences.
6. Cross-check against the encrypt direction for 3 random keys:
   - Reversed list of reference encrypt subkeys K1..K16 equals the bench-captured sequence.

Source files
------------

// File: rtl/des_dec_key_sched.sv
// DES subkey generator for decryption: issues K16..K1 one per ADV handshake,
// deriving each subkey by right-rotating the C/D halves of PC-1(KEY).
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for START; KEY sampled on the START edge
// S_ISSUE | SUBKEY/KIDX valid; ADV steps to the next lower index
// S_FIN   | one-cycle DONE pulse after K1 was consumed
module des_dec_key_sched (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [64:1] KEY,
  input  logic        ADV,
  output logic [48:1] SUBKEY,
  output logic [4:0]  KIDX,
  output logic        KEY_VALID,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_FIN   = 2'd2;

  // Tables use DES numbering: entry n names source bit n, bit 1 = MSB.
  localparam int PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [56:1] pc1(input logic [64:1] k);
    logic [56:1] r;
    r = '0;
    for (int i = 1; i <= 56; i++) r[57-i] = k[65-PC1_TAB[i-1]];
    return r;
  endfunction

  function automatic logic [48:1] pc2(input logic [56:1] cd);
    logic [48:1] r;
    r = '0;
    for (int i = 1; i <= 48; i++) r[49-i] = cd[57-PC2_TAB[i-1]];
    return r;
  endfunction

  function automatic logic [28:1] ror(input logic [28:1] v, input logic two);
    return two ? {v[2:1], v[28:3]} : {v[1], v[28:2]};
  endfunction

  logic [1:0]  state;
  logic [28:1] c_r;
  logic [28:1] d_r;
  logic        two_shift;

  // Parity bits never reach PC-1.
  logic unused_parity;
  assign unused_parity = ^{KEY[57], KEY[49], KEY[41], KEY[33],
                           KEY[25], KEY[17], KEY[9],  KEY[1]};

  // Undo encrypt round KIDX: rounds 1, 2, 9, 16 shifted by one, the rest by two.
  assign two_shift = !((KIDX == 5'd16) || (KIDX == 5'd9) || (KIDX == 5'd2));

  assign SUBKEY = pc2({c_r, d_r});

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      c_r       <= '0;
      d_r       <= '0;
      KIDX      <= '0;
      KEY_VALID <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            {c_r, d_r} <= pc1(KEY);
            KIDX       <= 5'd16;
            KEY_VALID  <= 1'b1;
            BUSY       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ADV) begin
            if (KIDX == 5'd1) begin
              KEY_VALID <= 1'b0;
              KIDX      <= '0;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
              state     <= S_FIN;
            end else begin
              c_r  <= ror(c_r, two_shift);
              d_r  <= ror(d_r, two_shift);
              KIDX <= KIDX - 5'd1;
            end
          end
        end
        S_FIN: begin
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          KEY_VALID <= 1'b0;
          KIDX      <= '0;
          BUSY      <= 1'b0;
          DONE      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Scoreboard bench for des_dec_key_sched: stimulus queues expected (KIDX, SUBKEY)
// pairs, a negedge monitor compares every valid cycle and pops on ADV.
module tb_des_dec_key_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [64:1] KEY;
  logic        ADV;
  logic [48:1] SUBKEY;
  logic [4:0]  KIDX;
  logic        KEY_VALID;
  logic        BUSY;
  logic        DONE;

  des_dec_key_sched dut (
    .CLK(CLK), .RST(RST), .START(START), .KEY(KEY), .ADV(ADV),
    .SUBKEY(SUBKEY), .KIDX(KIDX), .KEY_VALID(KEY_VALID), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  kidx;
    logic [47:0] sk;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [47:0] khand [1:16];
  logic [47:0] ref_ks [1:16];

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Encrypt-direction reference: left rotations, K1..K16.
  task automatic ref_enc(input logic [63:0] k);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 1; r <= 16; r++) begin
      int sh;
      sh = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
      for (int s = 0; s < sh; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) sk[47-j] = cd[56-PC2[j]];
      ref_ks[r] = sk;
    end
  endtask

  task automatic push_list(input int src);
    for (int i = 16; i >= 1; i--) begin
      exp_t e;
      e.kidx = 5'(i);
      e.sk   = (src == 0) ? khand[i] : (src == 1) ? ref_ks[i] : 48'h0;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt++;
    if (KEY_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_subkey: got kidx %0d subkey %h, nothing expected", KIDX, SUBKEY);
      end else begin
        check("kidx", 64'(KIDX), 64'(exp_q[0].kidx));
        check("subkey", 64'(SUBKEY), 64'(exp_q[0].sk));
        if (ADV) void'(exp_q.pop_front());
      end
    end
  end

  // mode 0: ADV held high; mode 1: random stalls of 0..5 cycles.
  task automatic run_sched(input logic [63:0] k, input int mode,
                           input logic [4:0] restart_at, input logic [63:0] k2,
                           input logic [4:0] rst_at);
    int ncyc, stall, d0;
    bit fin;
    d0 = done_cnt;
    fin = 0;
    ncyc = 0;
    stall = 0;
    @(posedge CLK); #1;
    KEY = k;
    START = 1'b1;
    ADV = (mode == 0);
    @(posedge CLK); #1;
    START = 1'b0;
    KEY = ~k;
    while (!fin && ncyc < 300) begin
      if (mode == 1) begin
        if (stall > 0) begin
          ADV = 1'b0;
          stall--;
        end else begin
          ADV = 1'b1;
          stall = $urandom_range(0, 5);
        end
      end
      if (restart_at != 0 && KIDX == restart_at) begin
        START = 1'b1;
        KEY = k2;
      end else START = 1'b0;
      if (rst_at != 0 && KIDX == rst_at) RST = 1'b1;
      @(negedge CLK);
      ncyc++;
      if (ncyc == 1) begin
        check("first_kidx", 64'(KIDX), 64'd16);
        check("first_busy", 64'(BUSY), 64'd1);
      end
      if (RST) fin = 1;
      else if (DONE) begin
        fin = 1;
        check("done_busy", 64'(BUSY), 64'd0);
        check("done_valid", 64'(KEY_VALID), 64'd0);
        check("done_kidx", 64'(KIDX), 64'd0);
        if (mode == 0) check("done_latency", 64'(ncyc), 64'd17);
      end
      @(posedge CLK); #1;
    end
    START = 1'b0;
    ADV = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no DONE after %0d cycles, required within 300", ncyc);
    end
    if (rst_at != 0) begin
      RST = 1'b0;
      exp_q.delete();
      @(negedge CLK);
      check("rst_subkey", 64'(SUBKEY), 64'd0);
      check("rst_kidx", 64'(KIDX), 64'd0);
      check("rst_valid", 64'(KEY_VALID), 64'd0);
      check("rst_busy", 64'(BUSY), 64'd0);
      check("rst_done", 64'(DONE), 64'd0);
      repeat (3) @(negedge CLK);
      check("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
    end else begin
      check("done_count", 64'(done_cnt - d0), 64'd1);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] rkeys [0:2];
    khand[1]  = 48'h1B02EFFC7072; khand[2]  = 48'h79AED9DBC9E5;
    khand[3]  = 48'h55FC8A42CF99; khand[4]  = 48'h72ADD6DB351D;
    khand[5]  = 48'h7CEC07EB53A8; khand[6]  = 48'h63A53E507B2F;
    khand[7]  = 48'hEC84B7F618BC; khand[8]  = 48'hF78A3AC13BFB;
    khand[9]  = 48'hE0DBEBEDE781; khand[10] = 48'hB1F347BA464F;
    khand[11] = 48'h215FD3DED386; khand[12] = 48'h7571F59467E9;
    khand[13] = 48'h97C5D1FABA41; khand[14] = 48'h5F43B7F2E73A;
    khand[15] = 48'hBF918D3D3F0A; khand[16] = 48'hCB3D8B0E17F5;
    rkeys[0] = 64'h0E329232EA6D0D73;
    rkeys[1] = 64'hA5C3F07B19D8E246;
    rkeys[2] = 64'h5B7E21C9D04F8A36;

    RST = 1'b1; START = 1'b0; ADV = 1'b0; KEY = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_subkey", 64'(SUBKEY), 64'd0);
    check("reset_kidx", 64'(KIDX), 64'd0);
    check("reset_valid", 64'(KEY_VALID), 64'd0);
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_done", 64'(DONE), 64'd0);
    RST = 1'b0;

    push_list(0);
    run_sched(KEY_A, 0, 5'd0, 64'h0, 5'd0);

    push_list(0);
    run_sched(KEY_A, 1, 5'd0, 64'h0, 5'd0);

    push_list(0);
    run_sched(KEY_A, 0, 5'd9, 64'hFEDCBA9876543210, 5'd0);

    push_list(0);
    run_sched(KEY_A, 0, 5'd0, 64'h0, 5'd7);
    push_list(2);
    run_sched(64'h0, 1, 5'd0, 64'h0, 5'd0);

    push_list(0);
    run_sched(KEY_A ^ 64'h0101010101010101, 1, 5'd0, 64'h0, 5'd0);

    for (int n = 0; n < 3; n++) begin
      ref_enc(rkeys[n]);
      push_list(1);
      run_sched(rkeys[n], 1, 5'd0, 64'h0, 5'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
